// File: rtl/cpu_jtag_debug_action_queue_if.sv
// Signal bundle between the JTAG debug command engine and its host/consumer.
// The slave modport is the engine side; the master modport drives the strobes and consumes pulses.
interface cpu_jtag_debug_action_queue_if #(
  parameter int unsigned IR_WIDTH   = 2,
  parameter int unsigned DR_WIDTH   = 38,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned NCH   = 1 << IR_WIDTH;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                vs_uir;
  logic                vs_udr;
  logic [IR_WIDTH-1:0] ir_in;
  logic [DR_WIDTH-1:0] sr;
  logic                cmd_ready;
  logic                overflow_clr;
  logic [DR_WIDTH-1:0] jdo;
  logic [NCH-1:0]      take_action;
  logic [NCH-1:0]      take_no_action;
  logic                cmd_pending;
  logic [LVL_W-1:0]    level;
  logic                overflow;

  modport master (
    output vs_uir, vs_udr, ir_in, sr, cmd_ready, overflow_clr,
    input  jdo, take_action, take_no_action, cmd_pending, level, overflow
  );

  modport slave (
    input  vs_uir, vs_udr, ir_in, sr, cmd_ready, overflow_clr,
    output jdo, take_action, take_no_action, cmd_pending, level, overflow
  );
endinterface

// File: rtl/cpu_jtag_debug_action_queue.sv
// Sysclk-side debug command engine: synchronises TCK update strobes, queues DR updates
// tagged with the latched IR, and replays them as a registered jdo word plus one-hot pulses.
module cpu_jtag_debug_action_queue #(
  parameter int unsigned IR_WIDTH    = 2,
  parameter int unsigned DR_WIDTH    = 38,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic                          i_clk,
  input logic                          i_reset,
  cpu_jtag_debug_action_queue_if.slave bus
);
  localparam int unsigned NCH   = 1 << IR_WIDTH;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = IR_WIDTH + DR_WIDTH;

  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic                   r_uir_prev;
  logic                   r_udr_prev;
  logic                   w_uir_ev;
  logic                   w_udr_ev;

  logic [IR_WIDTH-1:0]    r_ir_latched;
  logic [ENT_W-1:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [LVL_W-1:0]       r_level;

  logic [DR_WIDTH-1:0]    r_jdo;
  logic [NCH-1:0]         r_take_action;
  logic [NCH-1:0]         r_take_no_action;
  logic                   r_overflow;

  logic                   w_full;
  logic                   w_pending;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [ENT_W-1:0]       w_head;
  logic [IR_WIDTH-1:0]    w_head_ir;
  logic [DR_WIDTH-1:0]    w_head_data;
  logic [NCH-1:0]         w_onehot;

  // Chains and edge references reset high so a level already high at release is not an edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_uir_sync <= '1;
      r_udr_sync <= '1;
      r_uir_prev <= 1'b1;
      r_udr_prev <= 1'b1;
    end else begin
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
      r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
      r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    w_uir_ev    = r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;
    w_udr_ev    = r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;
    w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    w_pending   = (r_level != '0);
    w_pop       = w_pending & bus.cmd_ready;
    // When full, a same-cycle pop frees the slot the push writes into.
    w_push      = w_udr_ev & (~w_full | w_pop);
    w_drop      = w_udr_ev & w_full & ~w_pop;
    w_head      = r_mem[r_rd_ptr];
    w_head_ir   = w_head[ENT_W-1 -: IR_WIDTH];
    w_head_data = w_head[DR_WIDTH-1:0];
    w_onehot    = NCH'(1) << w_head_ir;
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset) begin
      r_mem[r_wr_ptr] <= {r_ir_latched, bus.sr};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ir_latched     <= '0;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_level          <= '0;
      r_jdo            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_overflow       <= 1'b0;
    end else begin
      if (w_uir_ev) begin
        r_ir_latched <= bus.ir_in;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_jdo    <= w_head_data;
      end
      r_level          <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      r_take_action    <= (w_pop &&  w_head_data[DR_WIDTH-1]) ? w_onehot : '0;
      r_take_no_action <= (w_pop && !w_head_data[DR_WIDTH-1]) ? w_onehot : '0;
      if (bus.overflow_clr) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.jdo            = r_jdo;
  assign bus.take_action    = r_take_action;
  assign bus.take_no_action = r_take_no_action;
  assign bus.cmd_pending    = w_pending;
  assign bus.level          = r_level;
  assign bus.overflow       = r_overflow;
endmodule

// File: tb/tb_cpu_jtag_debug_action_queue.sv
// Directed and random stimulus for the JTAG debug command engine, checked every cycle
// against a queue-based reference model of the command stream.
module tb_cpu_jtag_debug_action_queue;
  localparam int unsigned IR_W = 2;
  localparam int unsigned DR_W = 38;
  localparam int unsigned SYNC = 2;
  localparam int unsigned D    = 4;
  localparam int unsigned NCH  = 1 << IR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_jtag_debug_action_queue_if #(.IR_WIDTH(IR_W), .DR_WIDTH(DR_W), .FIFO_DEPTH(D)) dbg ();

  cpu_jtag_debug_action_queue #(
    .IR_WIDTH(IR_W), .DR_WIDTH(DR_W), .SYNC_STAGES(SYNC), .FIFO_DEPTH(D)
  ) u_dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (dbg)
  );

  typedef struct {
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] data;
  } cmd_t;

  cmd_t            mq[$];
  logic [IR_W-1:0] m_ir;
  logic [DR_W-1:0] m_jdo;
  logic [NCH-1:0]  m_act;
  logic [NCH-1:0]  m_nact;
  logic            m_ovf;
  logic            h_uir [SYNC+2];
  logic            h_udr [SYNC+2];
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    logic uev, dev, ovf_set;
    cmd_t c;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ir = '0; m_jdo = '0; m_act = '0; m_nact = '0; m_ovf = 1'b0;
      for (int i = 0; i < SYNC + 2; i++) begin
        h_uir[i] = 1'b1;
        h_udr[i] = 1'b1;
      end
    end else begin
      for (int i = SYNC + 1; i > 0; i--) begin
        h_uir[i] = h_uir[i-1];
        h_udr[i] = h_udr[i-1];
      end
      h_uir[0] = dbg.vs_uir;
      h_udr[0] = dbg.vs_udr;
      // A level first seen high at edge N becomes an event acted on at edge N+SYNC.
      uev = h_uir[SYNC] & ~h_uir[SYNC+1];
      dev = h_udr[SYNC] & ~h_udr[SYNC+1];
      m_act   = '0;
      m_nact  = '0;
      ovf_set = 1'b0;
      if (mq.size() > 0 && dbg.cmd_ready) begin
        c = mq.pop_front();
        m_jdo = c.data;
        if (c.data[DR_W-1]) m_act[c.ir] = 1'b1;
        else                m_nact[c.ir] = 1'b1;
      end
      if (dev) begin
        if (mq.size() < D) mq.push_back('{m_ir, dbg.sr});
        else               ovf_set = 1'b1;
      end
      if (dbg.overflow_clr) m_ovf = 1'b0;
      else if (ovf_set)     m_ovf = 1'b1;
      if (uev) m_ir = dbg.ir_in;
    end
    #1;
    check("jdo",            64'(dbg.jdo),            64'(m_jdo));
    check("take_action",    64'(dbg.take_action),    64'(m_act));
    check("take_no_action", 64'(dbg.take_no_action), 64'(m_nact));
    check("level",          64'(dbg.level),          64'(mq.size()));
    check("cmd_pending",    64'(dbg.cmd_pending),    64'(mq.size() > 0));
    check("overflow",       64'(dbg.overflow),       64'(m_ovf));
  endtask

  task automatic uir_scan(input logic [IR_W-1:0] ir);
    dbg.ir_in  = ir;
    dbg.vs_uir = 1'b1;
    repeat (3) step();
    dbg.vs_uir = 1'b0;
    repeat (3) step();
  endtask

  task automatic udr_scan(input logic [DR_W-1:0] val);
    dbg.sr     = val;
    dbg.vs_udr = 1'b1;
    repeat (3) step();
    dbg.vs_udr = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst              = 1'b1;
    dbg.vs_uir       = 1'b0;
    dbg.vs_udr       = 1'b0;
    dbg.ir_in        = '0;
    dbg.sr           = '0;
    dbg.cmd_ready    = 1'b0;
    dbg.overflow_clr = 1'b0;
    repeat (3) step();
    check("rst_level", 64'(dbg.level), 64'd0);
    check("rst_jdo",   64'(dbg.jdo),   64'd0);
    rst = 1'b0;
    repeat (2) step();

    // Single update with action bit set: pulse on channel 2 right after edge N+3.
    dbg.cmd_ready = 1'b1;
    uir_scan(2'd2);
    dbg.sr     = 38'h20_0000_00AB;
    dbg.vs_udr = 1'b1;
    repeat (3) step();
    check("t1_act_early", 64'(dbg.take_action), 64'd0);
    step();
    check("t1_act",  64'(dbg.take_action),    64'h4);
    check("t1_nact", 64'(dbg.take_no_action), 64'h0);
    check("t1_jdo",  64'(dbg.jdo),            64'h20_0000_00AB);
    dbg.vs_udr = 1'b0;
    repeat (3) step();

    // Action bit clear.
    udr_scan(38'h0_0000_1234);
    check("t2_jdo", 64'(dbg.jdo), 64'h1234);

    // Back-pressure with a dropped fifth update, then drain at full rate.
    dbg.cmd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) udr_scan(DR_W'(i));
    check("t3_level4",  64'(dbg.level),    64'd4);
    check("t3_no_ovf",  64'(dbg.overflow), 64'd0);
    udr_scan(38'd5);
    check("t3_level_full", 64'(dbg.level),    64'd4);
    check("t3_ovf",        64'(dbg.overflow), 64'd1);
    dbg.cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t3_drain_jdo", 64'(dbg.jdo), 64'(i));
    end
    step();
    check("t3_empty", 64'(dbg.level), 64'd0);
    check("t3_jdo_hold", 64'(dbg.jdo), 64'd4);
    dbg.overflow_clr = 1'b1;
    step();
    dbg.overflow_clr = 1'b0;
    check("t3_ovf_clr", 64'(dbg.overflow), 64'd0);

    // Push coinciding with pop while full.
    dbg.cmd_ready = 1'b0;
    for (int i = 11; i <= 14; i++) udr_scan(DR_W'(i));
    dbg.sr     = 38'd15;
    dbg.vs_udr = 1'b1;
    repeat (2) step();
    dbg.cmd_ready = 1'b1;
    step();
    dbg.cmd_ready = 1'b0;
    check("t4_level", 64'(dbg.level),    64'd4);
    check("t4_ovf",   64'(dbg.overflow), 64'd0);
    dbg.vs_udr = 1'b0;
    repeat (2) step();
    dbg.cmd_ready = 1'b1;
    repeat (6) step();
    check("t4_last", 64'(dbg.jdo), 64'd15);

    // Simultaneous strobes: push carries the old IR, next update the new one.
    uir_scan(2'd1);
    dbg.ir_in  = 2'd3;
    dbg.sr     = 38'h20_0000_0055;
    dbg.vs_uir = 1'b1;
    dbg.vs_udr = 1'b1;
    repeat (4) step();
    check("t5_ch1", 64'(dbg.take_action), 64'h2);
    dbg.vs_uir = 1'b0;
    dbg.vs_udr = 1'b0;
    repeat (2) step();
    dbg.sr     = 38'h20_0000_0066;
    dbg.vs_udr = 1'b1;
    repeat (4) step();
    check("t5_ch3", 64'(dbg.take_action), 64'h8);
    dbg.vs_udr = 1'b0;
    repeat (3) step();

    // Reset with queued commands and vs_udr held high.
    dbg.cmd_ready = 1'b0;
    udr_scan(38'd21);
    udr_scan(38'd22);
    dbg.sr     = 38'd23;
    dbg.vs_udr = 1'b1;
    repeat (3) step();
    check("t6_queued", 64'(dbg.level), 64'd3);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("t6_rst_level", 64'(dbg.level), 64'd0);
    repeat (5) step();
    check("t6_no_event", 64'(dbg.level), 64'd0);
    dbg.vs_udr = 1'b0;
    repeat (3) step();
    dbg.vs_udr = 1'b1;
    repeat (3) step();
    check("t6_new_event", 64'(dbg.level), 64'd1);
    dbg.vs_udr = 1'b0;
    dbg.cmd_ready = 1'b1;
    repeat (3) step();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) dbg.vs_uir = ~dbg.vs_uir;
      if ($urandom_range(3) == 0) dbg.vs_udr = ~dbg.vs_udr;
      if (!dbg.vs_uir) dbg.ir_in = IR_W'($urandom);
      if (!dbg.vs_udr) dbg.sr = {6'($urandom), 32'($urandom)};
      dbg.cmd_ready    = ($urandom_range(2) == 0);
      dbg.overflow_clr = ($urandom_range(15) == 0);
      rst              = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
